// File: rtl/zeroheti_obi_xbar_demux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : zeroheti_obi_xbar_demux (with zeroheti_pkg address map)
// Brief    : Single-host OBI demux routing core data requests to zeroHETI
//            slaves, in-order responses tracked by a small ID FIFO.
// Revision : 1.0 - initial release
// ============================================================================

package zeroheti_pkg;

   typedef struct packed {
      logic [31:0] base;
      logic [31:0] last;
   } addr_rule_t;

   typedef struct packed {
      addr_rule_t dbg;
      addr_rule_t imem;
      addr_rule_t dmem;
      addr_rule_t hetic;
      addr_rule_t uart;
      addr_rule_t mtimer;
      addr_rule_t ext;
   } addr_map_t;

   // Ranges are [base, last) except ext, whose last is inclusive.
   localparam addr_map_t AddrMap = '{
      dbg    : '{base: 32'h0000_0000, last: 32'h0000_1000},
      imem   : '{base: 32'h0001_0000, last: 32'h0001_8000},
      dmem   : '{base: 32'h0002_0000, last: 32'h0002_8000},
      hetic  : '{base: 32'h0000_1000, last: 32'h0000_2000},
      uart   : '{base: 32'h0000_2000, last: 32'h0000_2100},
      mtimer : '{base: 32'h0000_2100, last: 32'h0000_2114},
      ext    : '{base: 32'h0003_0000, last: 32'hFFFF_FFFF}
   };

endpackage

module zeroheti_obi_xbar_demux #(
   parameter int unsigned              MaxOutstanding = 2,
   parameter zeroheti_pkg::addr_map_t  Map            = zeroheti_pkg::AddrMap
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   output logic             gnt_o,
   input  logic [31:0]      addr_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [31:0]      wdata_i,
   output logic             rvalid_o,
   output logic [31:0]      rdata_o,
   output logic             err_o,
   output logic [6:0]       tgt_req_o,
   input  logic [6:0]       tgt_gnt_i,
   output logic [31:0]      tgt_addr_o,
   output logic             tgt_we_o,
   output logic [3:0]       tgt_be_o,
   output logic [31:0]      tgt_wdata_o,
   input  logic [6:0]       tgt_rvalid_i,
   input  logic [6:0][31:0] tgt_rdata_i,
   input  logic [6:0]       tgt_err_i
);

   localparam int                c_NUM_TGT = 7;
   localparam logic [2:0]        c_ERR_ID  = 3'd7;
   localparam int unsigned       c_PTR_W   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned       c_CNT_W   = $clog2(MaxOutstanding + 1);
   localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MaxOutstanding);
   localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(MaxOutstanding - 1);

   logic [31:0]          w_base [c_NUM_TGT];
   logic [31:0]          w_last [c_NUM_TGT];
   logic [6:0]           w_hit;
   logic [2:0]           w_id;
   logic [6:0]           w_id_oh;
   logic [2:0]           w_head_id;
   logic [6:0]           w_head_oh;
   logic                 w_empty;
   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;

   logic [2:0]           r_ids [MaxOutstanding];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic [2:0]           r_last_id;
   logic                 r_err_rv;

   function automatic logic [6:0] onehot7(input logic [2:0] id);
      logic [6:0] oh;
      for (int k = 0; k < c_NUM_TGT; k++) begin
         oh[k] = (id == 3'(k));
      end
      return oh;
   endfunction

   function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign w_base[0] = Map.dbg.base;    assign w_last[0] = Map.dbg.last;
   assign w_base[1] = Map.imem.base;   assign w_last[1] = Map.imem.last;
   assign w_base[2] = Map.dmem.base;   assign w_last[2] = Map.dmem.last;
   assign w_base[3] = Map.hetic.base;  assign w_last[3] = Map.hetic.last;
   assign w_base[4] = Map.uart.base;   assign w_last[4] = Map.uart.last;
   assign w_base[5] = Map.mtimer.base; assign w_last[5] = Map.mtimer.last;
   assign w_base[6] = Map.ext.base;    assign w_last[6] = Map.ext.last;

   // ext reaches the top of the address space, so its upper bound is inclusive.
   for (genvar k = 0; k < c_NUM_TGT; k++) begin : g_hit
      if (k == c_NUM_TGT - 1) begin : g_incl
         assign w_hit[k] = (addr_i >= w_base[k]) && (addr_i <= w_last[k]);
      end else begin : g_excl
         assign w_hit[k] = (addr_i >= w_base[k]) && (addr_i < w_last[k]);
      end
   end

   always_comb begin
      w_id = c_ERR_ID;
      for (int k = c_NUM_TGT - 1; k >= 0; k--) begin
         if (w_hit[k]) w_id = 3'(k);
      end
   end

   assign w_id_oh   = onehot7(w_id);
   assign w_empty   = (r_count == '0);
   assign w_head_id = r_ids[r_rd_ptr];
   assign w_head_oh = onehot7(w_head_id);

   // Switching targets only once the FIFO is empty keeps responses in order.
   assign w_accept = req_i & ~rst_i & (r_count < c_MAX_CNT)
                   & (w_empty | (w_id == r_last_id));

   always_comb begin
      tgt_req_o = '0;
      gnt_o     = 1'b0;
      if (w_accept) begin
         if (w_id == c_ERR_ID) begin
            gnt_o = 1'b1;
         end else begin
            tgt_req_o = w_id_oh;
            gnt_o     = |(w_id_oh & tgt_gnt_i);
         end
      end
   end

   assign tgt_addr_o  = addr_i;
   assign tgt_we_o    = we_i;
   assign tgt_be_o    = be_i;
   assign tgt_wdata_o = wdata_i;

   always_comb begin
      rvalid_o = 1'b0;
      rdata_o  = '0;
      err_o    = 1'b0;
      if (!rst_i && !w_empty) begin
         if (w_head_id == c_ERR_ID) begin
            rvalid_o = r_err_rv;
            err_o    = r_err_rv;
         end else begin
            for (int k = 0; k < c_NUM_TGT; k++) begin
               if (w_head_oh[k] && tgt_rvalid_i[k]) begin
                  rvalid_o = 1'b1;
                  rdata_o  = tgt_rdata_i[k];
                  err_o    = tgt_err_i[k];
               end
            end
         end
      end
   end

   assign w_push = req_i & gnt_o;
   assign w_pop  = rvalid_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_last_id <= c_ERR_ID;
         r_err_rv  <= 1'b0;
      end else begin
         if (w_push) begin
            r_ids[r_wr_ptr] <= w_id;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
            r_last_id       <= w_id;
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_err_rv <= w_push & (w_id == c_ERR_ID);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_zeroheti_obi_xbar_demux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_zeroheti_obi_xbar_demux
// Brief    : Scoreboard bench with latency-programmable slave models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zeroheti_obi_xbar_demux;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             req_i;
   logic             gnt_o;
   logic [31:0]      addr_i;
   logic             we_i;
   logic [3:0]       be_i;
   logic [31:0]      wdata_i;
   logic             rvalid_o;
   logic [31:0]      rdata_o;
   logic             err_o;
   logic [6:0]       tgt_req_o;
   logic [6:0]       tgt_gnt_i;
   logic [31:0]      tgt_addr_o;
   logic             tgt_we_o;
   logic [3:0]       tgt_be_o;
   logic [31:0]      tgt_wdata_o;
   logic [6:0]       tgt_rvalid_i;
   logic [6:0][31:0] tgt_rdata_i;
   logic [6:0]       tgt_err_i;

   typedef struct {
      int          slave;
      int          due;
      logic [31:0] data;
      logic        err;
   } pend_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   pend_t pq[$];
   exp_t  sb[$];
   int    lat [7];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;

   zeroheti_obi_xbar_demux #(.MaxOutstanding(2)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_i        (req_i),
      .gnt_o        (gnt_o),
      .addr_i       (addr_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .wdata_i      (wdata_i),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .err_o        (err_o),
      .tgt_req_o    (tgt_req_o),
      .tgt_gnt_i    (tgt_gnt_i),
      .tgt_addr_o   (tgt_addr_o),
      .tgt_we_o     (tgt_we_o),
      .tgt_be_o     (tgt_be_o),
      .tgt_wdata_o  (tgt_wdata_o),
      .tgt_rvalid_i (tgt_rvalid_i),
      .tgt_rdata_i  (tgt_rdata_i),
      .tgt_err_i    (tgt_err_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] slave_data(input int k, input logic [31:0] a);
      return {5'(k + 1), a[26:0]};
   endfunction

   function automatic logic slave_err(input logic [31:0] a);
      return (a[1:0] == 2'b11);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Slave models: one response per cycle, garbage on the data lines when idle.
   initial begin
      pend_t p;
      tgt_rvalid_i = '0;
      tgt_err_i    = '1;
      for (int k = 0; k < 7; k++) tgt_rdata_i[k] = 32'hDEAD_0000 | k;
      forever begin
         @(posedge clk);
         #1;
         tgt_rvalid_i = '0;
         tgt_err_i    = '1;
         for (int k = 0; k < 7; k++) tgt_rdata_i[k] = 32'hDEAD_0000 | k;
         if (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            tgt_rvalid_i[p.slave] = 1'b1;
            tgt_rdata_i[p.slave]  = p.data;
            tgt_err_i[p.slave]    = p.err;
         end
      end
   end

   // Response monitor: pop the scoreboard on every delivered response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rvalid_o) begin
            if (sb.size() == 0) begin
               chk("spurious_rvalid", 32'(rvalid_o), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_rdata", rdata_o, e.data);
               chk("rsp_err", 32'(err_o), 32'(e.err));
            end
         end else begin
            chk("idle_rdata", rdata_o, 32'd0);
            chk("idle_err", 32'(err_o), 32'd0);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic w, input int exp_id,
                        input int gdelay, output int waits);
      logic       ok;
      logic [6:0] exp_oh;
      req_i   = 1'b1;
      addr_i  = a;
      we_i    = w;
      be_i    = w ? 4'b0101 : 4'hF;
      wdata_i = ~a;
      if (gdelay > 0) tgt_gnt_i = '0;
      waits = 0;
      ok    = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (gnt_o) begin
            ok = 1'b1;
         end else begin
            waits++;
            @(posedge clk);
            #1;
            if (waits >= gdelay) tgt_gnt_i = '1;
         end
      end
      if (!ok) begin
         chk("grant_timeout", 32'd0, 32'd1);
      end else begin
         exp_oh = (exp_id == 7) ? 7'd0 : 7'(1 << exp_id);
         chk("tgt_req", 32'(tgt_req_o), 32'(exp_oh));
         chk("tgt_addr", tgt_addr_o, a);
         chk("tgt_fields", {tgt_wdata_o[27:0], tgt_be_o[2:0], tgt_we_o},
             {wdata_i[27:0], be_i[2:0], w});
         for (int k = 0; k < 7; k++) begin
            if (tgt_req_o[k] && tgt_gnt_i[k])
               pq.push_back('{k, cyc + lat[k], slave_data(k, a), slave_err(a)});
         end
         if (exp_id == 7) sb.push_back('{32'd0, 1'b1});
         else             sb.push_back('{slave_data(exp_id, a), slave_err(a)});
      end
      @(posedge clk);
      #1;
      req_i     = 1'b0;
      tgt_gnt_i = '1;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (sb.size() > 0 || pq.size() > 0); i++) @(posedge clk);
      if (sb.size() > 0 || pq.size() > 0) begin
         chk("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
         pq.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w0, w1, w2, seen;
      logic [31:0] b_addr [12];
      int          b_id   [12];
      b_addr = '{32'h0000_0FFF, 32'h0000_1000, 32'h0000_2113, 32'hFFFF_FFFF,
                 32'h0000_2114, 32'h0001_7FFC, 32'h0001_8000, 32'h0002_7FFF,
                 32'h0002_8000, 32'h0003_0000, 32'h0000_20FF, 32'h0000_2100};
      b_id   = '{0, 3, 5, 6, 7, 1, 7, 2, 7, 6, 4, 5};
      for (int k = 0; k < 7; k++) lat[k] = 1;

      rst_i     = 1'b1;
      req_i     = 1'b1;
      addr_i    = 32'h0002_0010;
      we_i      = 1'b0;
      be_i      = 4'hF;
      wdata_i   = '0;
      tgt_gnt_i = '1;
      @(negedge clk);
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_tgt_req", 32'(tgt_req_o), 32'd0);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      req_i = 1'b0;
      @(posedge clk);
      #1;

      // DMEM read, response two cycles after the grant
      lat[2] = 2;
      issue(32'h0002_0010, 1'b0, 2, 0, w0);
      chk("dmem_wait", 32'(w0), 32'd0);
      drain();

      // Unmapped access answered by the error responder one cycle later
      issue(32'h0000_2150, 1'b1, 7, 0, w0);
      chk("err_wait", 32'(w0), 32'd0);
      @(negedge clk);
      chk("err_rvalid", 32'(rvalid_o), 32'd1);
      chk("err_flag", 32'(err_o), 32'd1);
      @(posedge clk);
      #1;
      drain();

      // Back-to-back error requests stream one per cycle
      issue(32'h0000_8000, 1'b0, 7, 0, w0);
      issue(32'h0000_2114, 1'b0, 7, 0, w1);
      issue(32'h0000_FFFF, 1'b1, 7, 0, w2);
      chk("err_b2b_wait", 32'(w1 + w2), 32'd0);
      drain();

      // Target switch stalls until the UART response drains the FIFO
      lat[4] = 4;
      issue(32'h0000_2004, 1'b0, 4, 0, w0);
      issue(32'h0001_0000, 1'b0, 1, 0, w1);
      chk("switch_wait", 32'(w1), 32'd4);
      drain();

      // FIFO full: third DMEM request waits for the first pop
      lat[2] = 5;
      issue(32'h0002_0000, 1'b0, 2, 0, w0);
      issue(32'h0002_0004, 1'b1, 2, 0, w1);
      issue(32'h0002_0008, 1'b0, 2, 0, w2);
      chk("full_wait01", 32'(w0 + w1), 32'd0);
      chk("full_wait2", 32'(w2), 32'd4);
      drain();

      // Slave grant withheld for two cycles
      issue(32'h0001_0013, 1'b1, 1, 2, w0);
      chk("slow_gnt_wait", 32'(w0), 32'd2);
      drain();

      // Boundary decode table
      lat[2] = 1;
      lat[4] = 1;
      for (int i = 0; i < 12; i++) begin
         issue(b_addr[i], 1'($urandom_range(0, 1)), b_id[i], 0, w0);
      end
      drain();

      // Reset with two DMEM reads outstanding; late responses must be ignored
      lat[2] = 6;
      issue(32'h0002_0020, 1'b0, 2, 0, w0);
      issue(32'h0002_0027, 1'b0, 2, 0, w1);
      rst_i = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      seen  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tgt_rvalid_i[2]) begin
            chk("stray_rvalid", 32'(rvalid_o), 32'd0);
            seen++;
         end
      end
      chk("stray_seen", 32'(seen), 32'd2);
      @(posedge clk);
      #1;
      lat[2] = 1;
      issue(32'h0002_0030, 1'b0, 2, 0, w0);
      chk("post_rst_wait", 32'(w0), 32'd0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
